serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor, the inverse of the team's ripple-carry adder. It computes diff = a − b − b_in, one bit per clock, LSB first, through a single 1-bit full-subtractor cell. It sits behind a valid/ready handshake on both sides, so it can drop into datapaths that already use the parallel adder and trade area for latency.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block idle, will accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result held on diff/b_out
- out_ready  input  1  consumer takes result
- diff  output  WIDTH  (a − b − b_in) mod 2^WIDTH
- b_out  output  1  borrow out; 1 iff a < b + b_in (unsigned)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready, latch a, b, b_in into shift registers.
  - Clear bit counter; go to BUSY.
- BUSY: each cycle, process bit i = counter.
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into diff_reg from MSB side; operands shift right.
  - After bit WIDTH−1, b_out = br_next; go to DONE.
- DONE: out_valid=1; diff and b_out stable.
  - On out_ready, go to IDLE.
  - out_ready held high makes DONE last exactly one cycle.
- Operand inputs are sampled only on the accept edge; later changes on a/b/b_in have no effect.
- in_valid outside IDLE is ignored; nothing is queued.
- diff and b_out keep their last value in IDLE and BUSY. Only out_valid qualifies them.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream):
  - state=IDLE, in_ready=1, out_valid=0, diff=0, b_out=0, counter=0, internal borrow=0.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from the state register, never from inputs.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge (4 for default).
- Throughput: one operation per WIDTH+2 cycles minimum. This covers the accept edge, WIDTH BUSY edges and the output-handshake edge; IDLE lasts ≥1 cycle before the next accept.
- Backpressure: out_ready low keeps DONE indefinitely with outputs frozen.
- Reset mid-BUSY or mid-DONE: the operation is abandoned with no output. The block returns to IDLE with reset values immediately. The next accepted operation is computed correctly.
- WIDTH=1: BUSY lasts one cycle; counter width is max(1, clog2(WIDTH)).

## Structure
- Shared package serial_subtractor_pkg: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module fullsub (1-bit full subtractor: d, bo, a, b, bi), purely combinational, instantiated once.
- Top holds the FSM, counter, operand shift registers, borrow flop and result register.

## Test plan
- a=7, b=3, b_in=0, out_ready=1 → out_valid 4 edges after accept, diff=4'd4, b_out=0.
- a=2, b=5, b_in=0 → diff=4'b1101 (13), b_out=1.
- a=10, b=5, b_in=1 → diff=4'd4, b_out=0. Then a=0, b=0, b_in=1 → diff=4'd15, b_out=1.
- Backpressure case:
  - Stimulus: a=9, b=9; out_ready low for 5 cycles in DONE, with in_valid high and new operands (a=15, b=1) applied throughout.
  - Required: diff=0 and b_out=0 held, in_ready=0, new operands ignored.
  - After out_ready, in_ready returns. The next accept of a=15, b=1 gives diff=14.
- Reset_n pulsed low during BUSY after bit 2 of a=12, b=3 → outputs immediately at reset values, in_ready=1, no out_valid. A following a=12, b=3 gives diff=9, b_out=0.
- Exhaustive sweep for WIDTH=4 (all a, b, b_in), then 200 random operations at WIDTH=8 with random out_ready stalls → each result matches behavioural {b_out, diff} = {1'b0,a} − {1'b0,b} − b_in. Latency is always WIDTH.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the bit-counter sizing helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must index bits 0..w-1 and never collapse to zero width.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full subtractor: d = a - b - bi, bo set when the bit borrows.
module fullsub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Purely combinational difference and borrow.
    always_comb begin
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - b_in, LSB first, one
// bit per clock through a single full-subtractor cell.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready is high only in IDLE and out_valid only
// in DONE; both come straight from the state register. diff/b_out are
// meaningful only while out_valid is high and otherwise keep their last
// value.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             b_out_q;
    logic             d_bit;
    logic             bo_bit;
    logic             last_bit;

    fullsub u_fullsub (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (br_q),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // Bit select, last-bit detect and the working result with the new
    // bit inserted at the MSB (kept separate so diff stays stable in BUSY).
    always_comb begin
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        work_next = (work_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, shift one bit per BUSY cycle,
    // publish the result on the final bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br_q  <= b_in;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br_q   <= bo_bit;
                    work_q <= work_next;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q  <= work_next;
                        b_out_q <= bo_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign dbg_state = state_q;

endmodule
